// File: rtl/panel_key_conditioner.sv
// rtl/panel_key_conditioner.sv - front-panel key debounce, press/release/repeat pulses and switch capture
module panel_key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int SW_WIDTH        = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int SW_LOAD_KEY     = 0
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  input  logic [N_KEYS-1:0]   key_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic [N_KEYS-1:0]   repeat_en,
  output logic [N_KEYS-1:0]   key_level,
  output logic [N_KEYS-1:0]   key_press,
  output logic [N_KEYS-1:0]   key_release,
  output logic [SW_WIDTH-1:0] sw_value,
  output logic                sw_load
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0]   key_meta_q, key_meta_d, key_sync_q, key_sync_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [SW_WIDTH-1:0] sw_value_q, sw_value_d;
  logic                sw_load_q, sw_load_d;
  logic [N_KEYS-1:0]   press_next;

  // Polarity is normalised before the synchroniser so reset can clear it to "released".
  always_comb begin
    key_meta_d = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;
    key_sync_d = key_meta_q;
    sw_meta_d  = sw_raw;
    sw_sync_d  = sw_meta_q;
    sw_load_d  = press_next[SW_LOAD_KEY];
    sw_value_d = sw_value_q;
    if (sw_load_d) sw_value_d = sw_sync_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_value_q <= '0;
      sw_load_q  <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      sw_value_q <= sw_value_d;
      sw_load_q  <= sw_load_d;
    end
  end

  assign sw_value = sw_value_q;
  assign sw_load  = sw_load_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, rep_target;
    logic          rep_first_q, rep_first_d;
    logic          level_q, level_d, press_q, press_d, release_q, release_d;

    assign cnt_inc    = cnt_q + CW'(1);
    assign rep_target = rep_first_q ? PER_C : DLY_C;

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_first_d = rep_first_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          rep_first_d = 1'b0;
          cnt_d       = '0;
          if (key_sync_q[i]) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!key_sync_q[i]) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_C) begin
            state_d     = ST_HELD;
            level_d     = 1'b1;
            press_d     = 1'b1;
            cnt_d       = '0;
            rep_first_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!key_sync_q[i]) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CW'(1);
          end else if (!repeat_en[i]) begin
            cnt_d       = '0;
            rep_first_d = 1'b0;
          end else if (cnt_inc == rep_target) begin
            press_d     = 1'b1;
            cnt_d       = '0;
            rep_first_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RELEASE_WAIT: begin
          // A bounce back to pressed restarts the repeat delay from scratch.
          if (key_sync_q[i]) begin
            state_d     = ST_HELD;
            cnt_d       = '0;
            rep_first_d = 1'b0;
          end else if (cnt_q == DEB_C) begin
            state_d   = ST_RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
        state_q     <= ST_RELEASED;
        cnt_q       <= '0;
        rep_first_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        rep_first_q <= rep_first_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
      end
    end

    assign press_next[i]  = press_d;
    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_panel_key_conditioner.sv
// tb/tb_panel_key_conditioner.sv - per-cycle vector table with scoreboard for panel_key_conditioner
module tb_panel_key_conditioner;

    logic        CLOCK_50;
    logic        Reset;
    logic [1:0]  key_raw;
    logic [15:0] sw_raw;
    logic [1:0]  repeat_en;
    logic [1:0]  key_level, key_press, key_release;
    logic [15:0] sw_value;
    logic        sw_load;

    panel_key_conditioner #(
        .N_KEYS(2), .SW_WIDTH(16), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .SW_LOAD_KEY(0)
    ) dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .key_raw(key_raw), .sw_raw(sw_raw),
        .repeat_en(repeat_en), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .sw_value(sw_value), .sw_load(sw_load)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        rst;
        logic [1:0]  key;
        logic [15:0] sw;
        logic [1:0]  rep;
        logic [1:0]  lvl;
        logic [1:0]  prs;
        logic [1:0]  rel;
        logic [15:0] swv;
        logic        swl;
    } vec_t;

    vec_t vecs[512];
    vec_t sb[$];
    int   nv = 0;
    int   n_applied = 0;
    int   n_miscompare = 0;

    initial begin
        #100000;
        $display("FAIL: timeout waiting for vector table to complete (%0d applied)", n_applied);
        $finish;
    end

    task automatic hold(input int n, input logic rst, input logic [1:0] key, input logic [15:0] sw,
                        input logic [1:0] rep, input logic [1:0] lvl, input logic [15:0] swv);
        for (int k = 0; k < n; k++) begin
            vecs[nv].rst = rst;  vecs[nv].key = key; vecs[nv].sw  = sw;  vecs[nv].rep = rep;
            vecs[nv].lvl = lvl;  vecs[nv].prs = 2'b00; vecs[nv].rel = 2'b00;
            vecs[nv].swv = swv;  vecs[nv].swl = 1'b0;
            nv++;
        end
    endtask

    task automatic pulse(input int idx, input logic [1:0] p, input logic [1:0] r, input logic l);
        vecs[idx].prs = p;
        vecs[idx].rel = r;
        vecs[idx].swl = l;
    endtask

    initial begin
        int b;
        vec_t e;

        hold(2, 1, 2'b11, 16'h0000, 2'b00, 2'b00, 16'h0000);
        hold(3, 0, 2'b11, 16'h0000, 2'b00, 2'b00, 16'h0000);

        b = nv;
        hold(6,  0, 2'b10, 16'h0000, 2'b00, 2'b00, 16'h0000);
        hold(14, 0, 2'b10, 16'h0000, 2'b00, 2'b01, 16'h0000);
        pulse(b + 6, 2'b01, 2'b00, 1'b1);
        hold(6,  0, 2'b11, 16'h0000, 2'b00, 2'b01, 16'h0000);
        hold(6,  0, 2'b11, 16'h0000, 2'b00, 2'b00, 16'h0000);
        pulse(b + 26, 2'b00, 2'b01, 1'b0);

        hold(1, 0, 2'b10, 16'h0000, 2'b00, 2'b00, 16'h0000);
        hold(8, 0, 2'b11, 16'h0000, 2'b00, 2'b00, 16'h0000);

        b = nv;
        hold(6, 0, 2'b10, 16'h0010, 2'b00, 2'b00, 16'h0000);
        hold(4, 0, 2'b10, 16'h0010, 2'b00, 2'b01, 16'h0010);
        pulse(b + 6, 2'b01, 2'b00, 1'b1);
        hold(6, 0, 2'b11, 16'h0010, 2'b00, 2'b01, 16'h0010);
        hold(6, 0, 2'b11, 16'h0010, 2'b00, 2'b00, 16'h0010);
        pulse(b + 16, 2'b00, 2'b01, 1'b0);

        b = nv;
        hold(6,  0, 2'b10, 16'h0020, 2'b01, 2'b00, 16'h0010);
        hold(18, 0, 2'b10, 16'h0020, 2'b01, 2'b01, 16'h0020);
        hold(12, 0, 2'b10, 16'h0020, 2'b00, 2'b01, 16'h0020);
        pulse(b + 6,  2'b01, 2'b00, 1'b1);
        pulse(b + 16, 2'b01, 2'b00, 1'b1);
        pulse(b + 19, 2'b01, 2'b00, 1'b1);
        pulse(b + 22, 2'b01, 2'b00, 1'b1);
        hold(6, 0, 2'b11, 16'h0020, 2'b00, 2'b01, 16'h0020);
        hold(6, 0, 2'b11, 16'h0020, 2'b00, 2'b00, 16'h0020);
        pulse(b + 42, 2'b00, 2'b01, 1'b0);

        b = nv;
        hold(3, 0, 2'b01, 16'hABCD, 2'b00, 2'b00, 16'h0020);
        hold(1, 0, 2'b11, 16'hABCD, 2'b00, 2'b00, 16'h0020);
        hold(6, 0, 2'b01, 16'hABCD, 2'b00, 2'b00, 16'h0020);
        hold(6, 0, 2'b01, 16'hABCD, 2'b00, 2'b10, 16'h0020);
        pulse(b + 10, 2'b10, 2'b00, 1'b0);
        hold(6, 0, 2'b11, 16'hABCD, 2'b00, 2'b10, 16'h0020);
        hold(6, 0, 2'b11, 16'hABCD, 2'b00, 2'b00, 16'h0020);
        pulse(b + 22, 2'b00, 2'b10, 1'b0);

        b = nv;
        hold(4, 0, 2'b10, 16'h0040, 2'b00, 2'b00, 16'h0020);
        hold(2, 1, 2'b10, 16'h0040, 2'b00, 2'b00, 16'h0000);
        hold(6, 0, 2'b10, 16'h0040, 2'b00, 2'b00, 16'h0000);
        hold(4, 0, 2'b10, 16'h0040, 2'b00, 2'b01, 16'h0040);
        pulse(b + 12, 2'b01, 2'b00, 1'b1);
        hold(6, 0, 2'b11, 16'h0040, 2'b00, 2'b01, 16'h0040);
        hold(6, 0, 2'b11, 16'h0040, 2'b00, 2'b00, 16'h0040);
        pulse(b + 22, 2'b00, 2'b01, 1'b0);

        b = nv;
        hold(6, 0, 2'b00, 16'h0080, 2'b00, 2'b00, 16'h0040);
        hold(4, 0, 2'b00, 16'h0080, 2'b00, 2'b11, 16'h0080);
        pulse(b + 6, 2'b11, 2'b00, 1'b1);
        hold(6, 0, 2'b11, 16'h0080, 2'b00, 2'b11, 16'h0080);
        hold(6, 0, 2'b11, 16'h0080, 2'b00, 2'b00, 16'h0080);
        pulse(b + 16, 2'b00, 2'b11, 1'b0);

        Reset     = 1'b1;
        key_raw   = 2'b11;
        sw_raw    = 16'h0000;
        repeat_en = 2'b00;
        @(negedge CLOCK_50);
        if ({key_level, key_press, key_release, sw_value, sw_load} !== '0) begin
            n_miscompare++;
            $display("FAIL reset state: lvl=%b prs=%b rel=%b swv=%h swl=%b",
                     key_level, key_press, key_release, sw_value, sw_load);
        end

        for (int i = 0; i < nv; i++) begin
            Reset     = vecs[i].rst;
            key_raw   = vecs[i].key;
            sw_raw    = vecs[i].sw;
            repeat_en = vecs[i].rep;
            sb.push_back(vecs[i]);
            @(negedge CLOCK_50);
            e = sb.pop_front();
            n_applied++;
            if ({key_level, key_press, key_release, sw_value, sw_load} !==
                {e.lvl, e.prs, e.rel, e.swv, e.swl}) begin
                n_miscompare++;
                $display("FAIL vec%0d: got lvl=%b prs=%b rel=%b swv=%h swl=%b, want lvl=%b prs=%b rel=%b swv=%h swl=%b",
                         i, key_level, key_press, key_release, sw_value, sw_load,
                         e.lvl, e.prs, e.rel, e.swv, e.swl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        if (n_miscompare != 0)
            $display("FAIL: %0d miscompares", n_miscompare);
        else
            $display("PASS");
        $finish;
    end

endmodule

// File: doc/panel_key_conditioner.md
# panel_key_conditioner

Parametrised front-panel input conditioner for the DE2 wrapper: synchronises and debounces N push-buttons and converts them to single-cycle press/release pulses. Each channel can optionally auto-repeat while held. It also captures the slide switches atomically on a designated key press. It sits between the raw `KEY`/`SW` pins and the processor-facing I/O logic, replacing ad-hoc per-button edge detection.

## Interface
- `N_KEYS`, 2: number of button channels (1..8).
- `SW_WIDTH`, 16: slide-switch bus width.
- `ACTIVE_LOW`, 1: 1 = raw key pin low means pressed (DE2 keys); 0 = high means pressed.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 1.
- `REPEAT_DELAY`, 25000000: cycles from accepted press to first repeat pulse; must be >= 1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses; must be >= 1.
- `SW_LOAD_KEY`, 0: channel index whose press captures the switches.

- `CLOCK_50`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `key_raw`  in  N_KEYS  asynchronous button pins.
- `sw_raw`  in  SW_WIDTH  asynchronous slide switches.
- `repeat_en`  in  N_KEYS  per-channel auto-repeat enable (synchronous).
- `key_level`  out  N_KEYS  debounced level, 1 = pressed.
- `key_press`  out  N_KEYS  one-cycle pulse per accepted press or repeat.
- `key_release`  out  N_KEYS  one-cycle pulse per accepted release.
- `sw_value`  out  SW_WIDTH  switches captured at last load.
- `sw_load`  out  1  one-cycle pulse when `sw_value` updates.

## Operation
- Polarity: raw keys are XORed with `ACTIVE_LOW` so that internal 1 = pressed. Each key and switch bit passes through a 2-flop synchroniser.
- Per-channel FSM, with a counter of width `$clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1)`:
  - RELEASED: `key_level`=0. If synchronised input s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: if s=0, go back to RELEASED and clear cnt (a bounce). Otherwise, when cnt==`DEBOUNCE_CYCLES`, go to HELD, set `key_level`=1, pulse `key_press`, and clear cnt. Otherwise increment cnt.
  - HELD: if s=0, go to RELEASE_WAIT with cnt=1. Otherwise, if `repeat_en[i]` is set, count toward `REPEAT_DELAY` for the first repeat and `REPEAT_PERIOD` thereafter. On reaching the target, pulse `key_press` and clear cnt. When `repeat_en[i]`=0, cnt and the first-repeat flag are held cleared.
  - RELEASE_WAIT: if s=1, go back to HELD, clear cnt and restart the repeat delay. When cnt==`DEBOUNCE_CYCLES`, go to RELEASED, set `key_level`=0 and pulse `key_release`. Otherwise increment cnt.
  - With `DEBOUNCE_CYCLES`=1, a level change is accepted on the first stable cycle.
- Switch capture: in the cycle `key_press[SW_LOAD_KEY]` is registered, `sw_value` loads the synchronised switches and `sw_load` pulses. Repeat pulses on that channel also reload.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.

## Timing
- All outputs are registered.
- Reset values: `key_level`, `key_press`, `key_release`, `sw_value` and `sw_load` are all 0. All FSMs are RELEASED, counters are 0, and synchronisers hold the released level.
- Press latency: the raw edge is seen as s=1 after 2 cycles. If the input is stable, `key_press` and `key_level` rise exactly `DEBOUNCE_CYCLES`+2 cycles after the first sampled raw edge.
- Release latency has the same value.
- Any single-cycle glitch shorter than `DEBOUNCE_CYCLES` produces no output.
- Auto-repeat timing: the first repeat pulse comes `REPEAT_DELAY` cycles after the initial `key_press`. Later pulses come every `REPEAT_PERIOD` cycles.
- Reset asserted mid-operation: on the next edge, every FSM returns to RELEASED and no pulses are issued. A key still held after reset is accepted as a fresh press after the full latency.
- `key_press` and `key_release` on the same channel are never high in the same cycle.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `ACTIVE_LOW`=1.

- Clean press: drive `key_raw[0]` low at cycle 0 and hold it for 20 cycles → `key_press[0]` pulses once at cycle 6 and `key_level[0]`=1 from cycle 6. After release, `key_release[0]` pulses 6 cycles later.
- Bounce: drive `key_raw[1]` low for 3 cycles, high for 1, then low steadily → no pulse during the bounce. Exactly one `key_press[1]` occurs, 6 cycles after the final edge.
- Auto-repeat: with `repeat_en[0]`=1, hold key 0 → `key_press[0]` pulses at cycles 6, 16, 19 and 22. Dropping `repeat_en` stops further pulses while `key_level` stays 1.
- Switch load: set `sw_raw`=16'h0010 and press key 0 → `sw_value`=16'h0010 and `sw_load` pulses in the same cycle as `key_press[0]`. Pressing key 1 leaves `sw_value` unchanged.
- Reset mid-debounce: assert `Reset` at cycle 3 of PRESS_WAIT → all outputs are 0. With the key still held, a press is accepted 6 cycles after `Reset` drops.
- Simultaneous: press keys 0 and 1 on the same cycle → both `key_press` bits pulse on the same cycle.
